muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Pipeline-facing bundle of the HI/LO multiply/divide unit: EX-stage request,
// HI/LO read port and the stall/busy status returned to the pipeline.
interface muldiv_if;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        startE;
  logic [2:0]  opE;
  logic [1:0]  mfE;
  logic [31:0] HiLoOut;
  logic        busy;
  logic        stallE;

  modport master (
    output SrcAE, SrcBE, startE, opE, mfE,
    input  HiLoOut, busy, stallE
  );

  modport slave (
    input  SrcAE, SrcBE, startE, opE, mfE,
    output HiLoOut, busy, stallE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, followed by one sign-correction cycle.
module muldiv_unit (
  input  logic clk,
  input  logic reset_n,
  muldiv_if.slave bus
);

  localparam logic [2:0] OP_NONE0 = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NONE7 = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_div_q, is_div_d;
  logic        busy_q, busy_d;

  logic        op_valid, accept, signed_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    op_valid  = (bus.opE != OP_NONE0) && (bus.opE != OP_NONE7);
    accept    = bus.startE && op_valid && !busy_q;
    signed_op = (bus.opE == OP_MULT) || (bus.opE == OP_DIV);
    sign_a    = signed_op && bus.SrcAE[31];
    sign_b    = signed_op && bus.SrcBE[31];
    mag_a     = sign_a ? (32'd0 - bus.SrcAE) : bus.SrcAE;
    mag_b     = sign_b ? (32'd0 - bus.SrcBE) : bus.SrcBE;
  end

  // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
  // divide keeps the partial remainder in acc_hi and the dividend/quotient in acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_shift[31:0] - opb_q;
    prod_fix  = neg_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    quo_fix   = neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
    rem_fix   = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.opE)
            OP_MULT, OP_MULTU: begin
              state_d  = MUL;
              busy_d   = 1'b1;
              cnt_d    = 6'd0;
              is_div_d = 1'b0;
              acc_hi_d = 32'd0;
              acc_lo_d = mag_a;
              opb_d    = mag_b;
              neg_d    = sign_a ^ sign_b;
            end
            OP_DIV, OP_DIVU: begin
              busy_d   = 1'b1;
              cnt_d    = 6'd0;
              is_div_d = 1'b1;
              // A zero divisor skips iteration and lets FIX pass the fixed result through.
              if (bus.SrcBE == 32'd0) begin
                state_d   = FIX;
                acc_hi_d  = bus.SrcAE;
                acc_lo_d  = 32'hFFFF_FFFF;
                neg_d     = 1'b0;
                neg_rem_d = 1'b0;
              end else begin
                state_d   = DIV;
                acc_hi_d  = 32'd0;
                acc_lo_d  = mag_a;
                opb_d     = mag_b;
                neg_d     = sign_a ^ sign_b;
                neg_rem_d = sign_a;
              end
            end
            OP_MTHI: hi_d = bus.SrcAE;
            OP_MTLO: lo_d = bus.SrcAE;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_hi_d = mul_sum[32:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        cnt_d    = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      DIV: begin
        acc_hi_d = div_ge ? div_rem : div_shift[31:0];
        acc_lo_d = {acc_lo_q[30:0], div_ge};
        cnt_d    = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opb_q     <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.HiLoOut = (bus.mfE == 2'b10) ? hi_q :
                       (bus.mfE == 2'b11) ? lo_q : 32'd0;
  assign bus.busy    = busy_q;
  assign bus.stallE  = busy_q && (bus.mfE[1] || (bus.startE && op_valid));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model fills a scoreboard
// queue at issue time, entries are popped and compared when the unit finishes.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  exp_t sb_q[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] res;
    exp_t        e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        res = sp;
        e = {res[63:32], res[31:0]};
      end
      OP_MULTU: begin
        res = {32'd0, a} * {32'd0, b};
        e = {res[63:32], res[31:0]};
      end
      OP_DIV: begin
        if (b == 32'd0) e = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          e.lo = sq[31:0];
          e.hi = sr[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) e = {a, 32'hFFFF_FFFF};
        else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t exp_v;
    exp_t got;
    int   n;
    int   exp_lat;
    exp_lat = (((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0)) ? 1 : 33;
    @(negedge clk);
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.opE    = op;
    bus.startE = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n !== exp_lat) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_lat);
    end
    bus.mfE = 2'b10;
    #1;
    got.hi = bus.HiLoOut;
    bus.mfE = 2'b11;
    #1;
    got.lo = bus.HiLoOut;
    bus.mfE = 2'b00;
    exp_v = sb_q.pop_front();
    tests_run++;
    if (got.hi !== exp_v.hi) begin
      tests_failed++;
      $display("[TB] FAIL %s hi: got %h expected %h", name, got.hi, exp_v.hi);
    end
    tests_run++;
    if (got.lo !== exp_v.lo) begin
      tests_failed++;
      $display("[TB] FAIL %s lo: got %h expected %h", name, got.lo, exp_v.lo);
    end
    model_hi = exp_v.hi;
    model_lo = exp_v.lo;
  endtask

  task automatic test_reset;
    #3;
    bus.startE = 1'b1;
    bus.opE    = OP_MULT;
    bus.mfE    = 2'b10;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.stallE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: busy=%b stallE=%b expected 0 0", bus.busy, bus.stallE);
    end
    tests_run++;
    if (bus.HiLoOut !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.HiLoOut);
    end
    bus.mfE = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.HiLoOut);
    end
    bus.mfE = 2'b00;
    // First rising edge after release must already accept a request.
    @(negedge clk);
    reset_n    = 1'b1;
    bus.opE    = OP_MTLO;
    bus.SrcAE  = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    bus.mfE    = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("[TB] FAIL first_accept: got %h expected a5a5a5a5", bus.HiLoOut);
    end
    bus.mfE  = 2'b00;
    model_lo = 32'hA5A5_A5A5;
  endtask

  task automatic test_mul;
    logic [2:0] op;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run_op(OP_MULTU, 32'h0000_0000, 32'h1234_5678, "multu_zero");
    for (int i = 0; i < 4; i++) begin
      op = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      run_op(op, $urandom, $urandom, "mul_rand");
    end
  endtask

  task automatic test_div;
    logic [2:0] op;
    logic [31:0] b;
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, "divu_one");
    run_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, "div_negdivisor");
    for (int i = 0; i < 4; i++) begin
      op = (i % 2 == 0) ? OP_DIV : OP_DIVU;
      b  = $urandom;
      if (i == 3) b = b >> 20;
      if (b == 32'd0) b = 32'd3;
      run_op(op, $urandom, b, "div_rand");
    end
  endtask

  task automatic test_div_zero;
    run_op(OP_DIVU, 32'h0000_0005, 32'h0000_0000, "divu_by_zero");
    run_op(OP_DIV,  32'h8765_4321, 32'h0000_0000, "div_by_zero");
  endtask

  task automatic test_mt;
    @(negedge clk);
    bus.startE = 1'b1;
    bus.opE    = OP_MTLO;
    bus.SrcAE  = 32'h1234_5678;
    bus.mfE    = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== model_lo) begin
      tests_failed++;
      $display("[TB] FAIL mtlo_same_cycle: got %h expected %h", bus.HiLoOut, model_lo);
    end
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    tests_run++;
    if (bus.HiLoOut !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mtlo_write: got %h busy=%b expected 12345678 busy=0", bus.HiLoOut, bus.busy);
    end
    bus.mfE = 2'b10;
    #1;
    tests_run++;
    if (bus.HiLoOut !== model_hi) begin
      tests_failed++;
      $display("[TB] FAIL mtlo_hi_kept: got %h expected %h", bus.HiLoOut, model_hi);
    end
    model_lo = 32'h1234_5678;
    @(negedge clk);
    bus.startE = 1'b1;
    bus.opE    = OP_MTHI;
    bus.SrcAE  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    tests_run++;
    if (bus.HiLoOut !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL mthi_write: got %h expected deadbeef", bus.HiLoOut);
    end
    bus.mfE = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== model_lo) begin
      tests_failed++;
      $display("[TB] FAIL mthi_lo_kept: got %h expected %h", bus.HiLoOut, model_lo);
    end
    bus.mfE  = 2'b00;
    model_hi = 32'hDEAD_BEEF;
  endtask

  task automatic test_stall;
    exp_t exp_v;
    int   n;
    @(negedge clk);
    bus.SrcAE  = 32'hFFFF_FF00;
    bus.SrcBE  = 32'h0000_0007;
    bus.opE    = OP_DIV;
    bus.startE = 1'b1;
    sb_q.push_back(model(OP_DIV, 32'hFFFF_FF00, 32'h0000_0007));
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    @(posedge clk);
    #1;
    bus.mfE = 2'b10;
    #1;
    n = 0;
    while (bus.stallE === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n !== 32) begin
      tests_failed++;
      $display("[TB] FAIL mfhi_stall_cycles: got %0d expected 32", n);
    end
    exp_v = sb_q.pop_front();
    tests_run++;
    if (bus.HiLoOut !== exp_v.hi || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mfhi_after_stall: got %h busy=%b expected %h busy=0", bus.HiLoOut, bus.busy, exp_v.hi);
    end
    bus.mfE = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== exp_v.lo) begin
      tests_failed++;
      $display("[TB] FAIL mflo_after_stall: got %h expected %h", bus.HiLoOut, exp_v.lo);
    end
    bus.mfE  = 2'b00;
    model_hi = exp_v.hi;
    model_lo = exp_v.lo;
  endtask

  task automatic test_back_to_back;
    exp_t exp_v;
    int   n;
    @(negedge clk);
    bus.SrcAE  = 32'h7654_3210;
    bus.SrcBE  = 32'hFEDC_BA98;
    bus.opE    = OP_MULT;
    bus.startE = 1'b1;
    sb_q.push_back(model(OP_MULT, 32'h7654_3210, 32'hFEDC_BA98));
    @(posedge clk);
    #1;
    // MTHI presented while the multiply is in flight: must stall and leave Hi alone.
    bus.opE   = OP_MTHI;
    bus.SrcAE = 32'hCAFE_F00D;
    bus.SrcBE = 32'h0;
    bus.mfE   = 2'b10;
    #1;
    tests_run++;
    if (bus.stallE !== 1'b1 || bus.HiLoOut !== model_hi) begin
      tests_failed++;
      $display("[TB] FAIL mthi_busy: stallE=%b hi=%h expected 1 %h", bus.stallE, bus.HiLoOut, model_hi);
    end
    n = 0;
    while (bus.stallE === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n !== 33) begin
      tests_failed++;
      $display("[TB] FAIL mthi_stall_cycles: got %0d expected 33", n);
    end
    exp_v = sb_q.pop_front();
    tests_run++;
    if (bus.HiLoOut !== exp_v.hi) begin
      tests_failed++;
      $display("[TB] FAIL mult_hi_before_mthi: got %h expected %h", bus.HiLoOut, exp_v.hi);
    end
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    tests_run++;
    if (bus.HiLoOut !== 32'hCAFE_F00D || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mthi_after_busy: got %h busy=%b expected cafef00d busy=0", bus.HiLoOut, bus.busy);
    end
    bus.mfE = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== exp_v.lo) begin
      tests_failed++;
      $display("[TB] FAIL mult_lo_kept: got %h expected %h", bus.HiLoOut, exp_v.lo);
    end
    bus.mfE  = 2'b00;
    model_hi = 32'hCAFE_F00D;
    model_lo = exp_v.lo;
  endtask

  task automatic test_reset_mid;
    int busy_seen;
    @(negedge clk);
    bus.SrcAE  = 32'h0001_0003;
    bus.SrcBE  = 32'h0002_0005;
    bus.opE    = OP_MULT;
    bus.startE = 1'b1;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    bus.mfE = 2'b10;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.HiLoOut !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hi: busy=%b hi=%h expected 0 00000000", bus.busy, bus.HiLoOut);
    end
    bus.mfE = 2'b11;
    #1;
    tests_run++;
    if (bus.HiLoOut !== 32'd0 || bus.stallE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_lo: lo=%h stallE=%b expected 00000000 0", bus.HiLoOut, bus.stallE);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    tests_run++;
    if (busy_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_busy_after: busy cycles %0d expected 0", busy_seen);
    end
    tests_run++;
    if (bus.HiLoOut !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_lo_after: got %h expected 00000000", bus.HiLoOut);
    end
    bus.mfE = 2'b10;
    #1;
    tests_run++;
    if (bus.HiLoOut !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hi_after: got %h expected 00000000", bus.HiLoOut);
    end
    bus.mfE = 2'b00;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_hi     = 32'd0;
    model_lo     = 32'd0;
    reset_n      = 1'b0;
    bus.startE   = 1'b0;
    bus.opE      = 3'b000;
    bus.mfE      = 2'b00;
    bus.SrcAE    = 32'd0;
    bus.SrcBE    = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mt();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
